therm2bin_sync: RTL and testbench
=================================

Name: therm2bin_sync

Overview:
- Registered thermometer-to-binary decoder. It converts the 31-bit thermometer control/measurement code of the locking loop back into a 5-bit binary value.
- It sits on the return path from the thermometer-coded DCO/TDC word to the loop controller and lock detector.
- It adds 3-bit majority bubble correction, a bubble error flag and a code-stability (lock) indicator.

Parameters:
- N_BIN, 5, binary width. N_THERM = 2**N_BIN-1 (31) is derived, not overridable.
- STABLE_CNT, 8, consecutive identical valid outputs required before stable asserts; range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies in on this cycle.
- in  input  31  thermometer code; bit i set means value > i.
- out_valid  output  1  out is updated this cycle.
- out  output  5  decoded binary value, held between valid cycles.
- bubble_err  output  1  sticky-per-sample flag: the sample that produced this out contained a bubble.
- stable  output  1  out has been identical for STABLE_CNT consecutive valid outputs.

Behaviour:
- Reset (rstn low, asynchronous): out=0, out_valid=0, bubble_err=0, stable=0. Pipeline valid bits cleared, stability counter=0. Takes effect mid-pipeline; in-flight samples are discarded.
- Stage 1: on in_valid=1, register in to t1 and set v1=1; otherwise v1=0 and t1 holds.
- Stage 2: corrected bit c[i] = majority(t1[i-1], t1[i], t1[i+1]), with t1[-1]=1 and t1[31]=0 as boundary values. Raw error e = OR over i of (t1[i+1] & ~t1[i]). Register c, e and v2=v1.
- Stage 3: when v2=1: out = popcount(c), 0..31; bubble_err = e; out_valid = 1. When v2=0: out_valid=0; out and bubble_err hold.
- Latency: in_valid at cycle N gives out_valid at cycle N+3, counting the output register. Full throughput: one sample per cycle, back-to-back allowed, no backpressure.
- Stability counter (8 bit):
  - On each out_valid, if the new out equals the previous out, increment, saturating at STABLE_CNT; else reset to 1.
  - The first valid output after reset loads 1.
  - stable = (counter == STABLE_CNT), registered together with out, so it is valid the same cycle as out_valid.
  - Cycles without out_valid neither increment nor clear the counter.
- Boundaries:
  - in=0 gives out=0.
  - in=all-ones gives out=31.
  - An isolated single-bit bubble is corrected. Example: 0x0000_00F7 gives 8, with bubble_err=1.
  - A non-thermometer pattern with multiple bubbles still yields popcount of the corrected word and bubble_err=1. No saturation beyond 31.
  - STABLE_CNT=1: stable asserts on every valid output.

Optional Feature:
- Macro THERM2BIN_HYST_EN enables output hysteresis.
- Defined: out changes only if the new decoded value differs from the held out by 2 or more, or the same new value is decoded on two consecutive valid samples. Otherwise out holds and out_valid still pulses. The stability counter compares the held (post-hysteresis) out.
- Undefined: out follows every decoded value as above.

Decomposition:
- Package therm_pkg:
  - localparams N_BIN=5 and N_THERM=31.
  - typedefs therm_t (logic [N_THERM-1:0]) and bin_t (logic [N_BIN-1:0]), shared with bin2therm users.
  - function is_therm(therm_t) for bench checks.
- Sub-module therm_popcount: purely combinational adder tree, therm_t to bin_t, instantiated in stage 3.

Test Plan:
- Reset check: hold rstn low with in_valid toggling, then release at cycle 5 → outputs remain 0 until 3 cycles after the first post-reset in_valid. Assert rstn low mid-stream → out_valid drops immediately.
- Sweep: drive all 32 clean codes 0x0, 0x1, 0x3 … 0x7FFF_FFFF back-to-back → out = 0..31 in order at latency 3, bubble_err = 0 throughout.
- Bubble: in = 0x0000_00F7 → out = 8, bubble_err = 1. in = 0x0000_0009 → out = 1, bubble_err = 1.
- Stability: 8 valid samples of 0x0000_FFFF with STABLE_CNT = 8 → stable rises with the 8th out = 16. A 9th sample of 0x0001_FFFF (17) → stable = 0, counter = 1. Idle gaps between samples do not clear the count.
- Gapped valid: in_valid pattern 1,0,0,1 → exactly two out_valid pulses 3 cycles after each; out holds in between.
- THERM2BIN_HYST_EN: held out = 10, sample decodes 11 → out stays 10. A second 11 → out = 11. A sample decoding 13 → out = 13 immediately.

Source files
------------

// File: rtl/therm_pkg.sv
// Shared thermometer/binary types for the locking-loop return path.
// Used by therm2bin_sync and by bin2therm users.
package therm_pkg;

   localparam int N_BIN   = 5;
   localparam int N_THERM = 2**N_BIN - 1;

   typedef logic [N_THERM-1:0] therm_t;
   typedef logic [N_BIN-1:0]   bin_t;

   // A clean thermometer code is a contiguous run of ones starting at bit 0,
   // so adding one to it produces a value with no bits in common.
   function automatic logic is_therm(input therm_t t);
      return (t & (t + therm_t'(1))) == '0;
   endfunction

endpackage

// File: rtl/therm_popcount.sv
// Combinational population count of a thermometer-width word.
// Balanced adder tree: pairs of bits, then pairs of partial sums.
module therm_popcount
   import therm_pkg::*;
(
   input  therm_t therm,
   output bin_t   bin_val
);

   logic [31:0]      bits;
   logic [1:0]       l1 [16];
   logic [2:0]       l2 [8];
   logic [3:0]       l3 [4];
   logic [N_BIN-1:0] l4 [2];

   // Reduce 32 bits (31 plus a zero pad) through four levels of pairwise sums.
   always_comb begin
      bits = {1'b0, therm};
      for (int k = 0; k < 16; k++) l1[k] = {1'b0, bits[2*k]} + {1'b0, bits[2*k+1]};
      for (int k = 0; k < 8; k++)  l2[k] = {1'b0, l1[2*k]} + {1'b0, l1[2*k+1]};
      for (int k = 0; k < 4; k++)  l3[k] = {1'b0, l2[2*k]} + {1'b0, l2[2*k+1]};
      for (int k = 0; k < 2; k++)  l4[k] = {1'b0, l3[2*k]} + {1'b0, l3[2*k+1]};
      // Total never exceeds 31 because the pad bit is zero, so 5 bits suffice.
      bin_val = l4[0] + l4[1];
   end

endmodule

// File: rtl/therm2bin_sync.sv
// Registered thermometer-to-binary decoder with 3-bit majority bubble
// correction, a per-sample bubble flag and a code-stability indicator.
// Three register stages: capture, correct, decode/output.
// Optional build macro THERM2BIN_HYST_EN adds output hysteresis: the held
// output only moves on a jump of 2 or more, or on two consecutive identical
// decodes.
module therm2bin_sync
   import therm_pkg::*;
#(
   parameter int STABLE_CNT = 8
) (
   input  logic   clk,
   input  logic   rstn,
   input  logic   in_valid,
   input  therm_t in,
   output logic   out_valid,
   output bin_t   out,
   output logic   bubble_err,
   output logic   stable
);

   localparam logic [7:0] SC = 8'(STABLE_CNT);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // pipeline control
   logic v1_q, v1_d, v2_q, v2_d;
   // pipeline data
   therm_t t1_q, t1_d, c_q, c_d;
   logic   e_q, e_d;
   // output / stability state
   bin_t       out_q, out_d, dec, new_out;
   logic       ovld_q, ovld_d, bub_q, bub_d, stable_q, stable_d;
   logic [7:0] cnt_q, cnt_d;
   logic [N_THERM+1:0] ext;

`ifdef THERM2BIN_HYST_EN
   bin_t last_dec_q, last_dec_d;
   logic have_dec_q, have_dec_d;
   logic big_step;
`endif

   // Stage 1: capture the input word on valid, otherwise hold it.
   always_comb begin
      v1_d = in_valid;
      t1_d = in_valid ? in : t1_q;
   end

   // Stage 2: majority-correct each bit against its neighbours; bit -1 is
   // treated as 1 and bit 31 as 0 so the code edges are never "corrected".
   always_comb begin
      ext = {1'b0, t1_q, 1'b1};
      c_d = '0;
      for (int i = 0; i < N_THERM; i++) c_d[i] = maj3(ext[i], ext[i+1], ext[i+2]);
      e_d  = |(t1_q[N_THERM-1:1] & ~t1_q[N_THERM-2:0]);
      v2_d = v1_q;
   end

   therm_popcount u_popcount (
      .therm   (c_q),
      .bin_val (dec)
   );

   // Stage 3: choose the new output value (hysteresis optional) and update
   // the stability counter on valid samples only.
   always_comb begin
`ifdef THERM2BIN_HYST_EN
      big_step   = (dec > out_q) ? ((dec - out_q) >= bin_t'(2)) : ((out_q - dec) >= bin_t'(2));
      new_out    = (big_step || (have_dec_q && dec == last_dec_q)) ? dec : out_q;
      last_dec_d = v2_q ? dec : last_dec_q;
      have_dec_d = have_dec_q | v2_q;
`else
      new_out = dec;
`endif
      ovld_d   = v2_q;
      out_d    = out_q;
      bub_d    = bub_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (v2_q) begin
         out_d = new_out;
         bub_d = e_q;
         if (cnt_q == 8'd0 || new_out != out_q) cnt_d = 8'd1;
         else if (cnt_q >= SC)                  cnt_d = SC;
         else                                   cnt_d = cnt_q + 8'd1;
         stable_d = (cnt_d == SC);
      end
   end

   // Control and output state: cleared asynchronously so in-flight samples die.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         ovld_q     <= 1'b0;
         out_q      <= '0;
         bub_q      <= 1'b0;
         cnt_q      <= 8'd0;
         stable_q   <= 1'b0;
`ifdef THERM2BIN_HYST_EN
         last_dec_q <= '0;
         have_dec_q <= 1'b0;
`endif
      end else begin
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         ovld_q     <= ovld_d;
         out_q      <= out_d;
         bub_q      <= bub_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
`ifdef THERM2BIN_HYST_EN
         last_dec_q <= last_dec_d;
         have_dec_q <= have_dec_d;
`endif
      end
   end

   // Datapath registers: qualified by the valid bits, so no reset needed.
   always_ff @(posedge clk) begin
      t1_q <= t1_d;
      c_q  <= c_d;
      e_q  <= e_d;
   end

   assign out_valid  = ovld_q;
   assign out        = out_q;
   assign bubble_err = bub_q;
   assign stable     = stable_q;

endmodule

// File: tb/tb_therm2bin_sync.sv
// Bench for therm2bin_sync: directed vectors, a spec-level model queue
// checked every cycle, and literal expectations on selected samples.
module tb_therm2bin_sync;
   import therm_pkg::*;

   localparam int SCNT = 8;
`ifdef THERM2BIN_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   logic   clk = 1'b0;
   logic   rstn = 1'b0;
   logic   in_valid = 1'b0;
   therm_t tin = '0;
   logic   out_valid, bubble_err, stable;
   bin_t   out;

   therm2bin_sync #(.STABLE_CNT(SCNT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in         (tin),
      .out_valid  (out_valid),
      .out        (out),
      .bubble_err (bubble_err),
      .stable     (stable)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int due;
      int out;
      int bub;
      int stb;
      int lit_out;
      int lit_bub;
      int lit_stb;
   } exp_t;

   exp_t eq[$];

   // model state: held output, stability count, last decode (hysteresis)
   int m_out = 0, m_cnt = 0, m_last = 0;
   bit m_have = 0;
   // values the outputs must hold between valid pulses
   int ho_out = 0, ho_bub = 0, ho_stb = 0;

   // Decoded value: number of bits whose 3-bit neighbourhood is mostly ones.
   function automatic int model_dec(input therm_t t);
      int n = 0;
      for (int i = 0; i < N_THERM; i++) begin
         int s;
         s = int'(t[i]);
         s += (i == 0) ? 1 : int'(t[i-1]);
         s += (i == N_THERM-1) ? 0 : int'(t[i+1]);
         if (s >= 2) n++;
      end
      return n;
   endfunction

   task automatic model_push(input therm_t t, input int lo, input int lb, input int ls);
      exp_t e;
      int dec, nv, d;
      dec = model_dec(t);
      nv  = dec;
      if (HYST) begin
         d  = (dec > m_out) ? dec - m_out : m_out - dec;
         nv = (d >= 2 || (m_have && dec == m_last)) ? dec : m_out;
         m_last = dec;
         m_have = 1;
      end
      if (m_cnt == 0 || nv != m_out) m_cnt = 1;
      else if (m_cnt < SCNT) m_cnt++;
      m_out = nv;
      e.due = cyc + 3;
      e.out = nv;
      e.bub = is_therm(t) ? 0 : 1;
      e.stb = (m_cnt == SCNT) ? 1 : 0;
      e.lit_out = lo;
      e.lit_bub = lb;
      e.lit_stb = ls;
      eq.push_back(e);
   endtask

   task automatic model_reset();
      eq.delete();
      m_out = 0; m_cnt = 0; m_last = 0; m_have = 0;
      ho_out = 0; ho_bub = 0; ho_stb = 0;
   endtask

   // One clock of stimulus; lo/lb/ls are literal expectations (-1 = none).
   task automatic step(input therm_t v, input logic vld, input int lo, input int lb, input int ls);
      tin      = v;
      in_valid = vld;
      if (vld && rstn) model_push(v, lo, lb, ls);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(tin, 1'b0, -1, -1, -1);
   endtask

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_out", int'(out), 0);
         chk("rst_bubble_err", int'(bubble_err), 0);
         chk("rst_stable", int'(stable), 0);
      end else if (eq.size() > 0 && eq[0].due == cyc) begin
         e = eq.pop_front();
         chk("out_valid_pulse", int'(out_valid), 1);
         chk("out", int'(out), e.out);
         chk("bubble_err", int'(bubble_err), e.bub);
         chk("stable", int'(stable), e.stb);
         if (e.lit_out >= 0) chk("lit_out", int'(out), e.lit_out);
         if (e.lit_bub >= 0) chk("lit_bubble_err", int'(bubble_err), e.lit_bub);
         if (e.lit_stb >= 0) chk("lit_stable", int'(stable), e.lit_stb);
         ho_out = e.out; ho_bub = e.bub; ho_stb = e.stb;
      end else begin
         chk("out_valid_idle", int'(out_valid), 0);
         chk("out_hold", int'(out), ho_out);
         chk("bubble_err_hold", int'(bubble_err), ho_bub);
         chk("stable_hold", int'(stable), ho_stb);
         if (eq.size() > 0 && eq[0].due < cyc) begin
            chk("missed_output", 0, 1);
            void'(eq.pop_front());
         end
      end
   end

   function automatic int nh(input int v);
      return HYST ? -1 : v;
   endfunction

   initial begin
      therm_t code;
      // Reset held with in_valid toggling; nothing may emerge.
      rstn = 1'b0;
      for (int i = 0; i < 5; i++) step(therm_t'(32'h0000_FFFF), logic'(i % 2 == 0), -1, -1, -1);
      in_valid = 1'b0;
      rstn = 1'b1;
      idle(4);

      // Sweep all clean codes back-to-back.
      for (int k = 0; k <= N_THERM; k++) begin
         code = therm_t'((64'd1 << k) - 64'd1);
         step(code, 1'b1, nh(k), 0, -1);
      end
      idle(4);

      // Bubbles.
      step(therm_t'(32'h0000_00F7), 1'b1, nh(8), 1, -1);
      step(therm_t'(32'h0000_0009), 1'b1, nh(1), 1, -1);
      step(therm_t'(32'h5555_5555), 1'b1, nh(16), 1, -1);
      step(therm_t'(32'h7FFF_FFFF), 1'b1, 31, 0, -1);
      step(therm_t'(32'h0000_0000), 1'b1, 0, 0, -1);
      idle(4);

      // Stability with idle gaps between samples.
      for (int i = 1; i <= 8; i++) begin
         step(therm_t'(32'h0000_FFFF), 1'b1, 16, 0, HYST ? -1 : int'(i == 8));
         idle(2);
      end
      step(therm_t'(32'h0001_FFFF), 1'b1, nh(17), 0, nh(0));
      idle(4);

      // Gapped valid 1,0,0,1.
      step(therm_t'(32'h0000_0003), 1'b1, nh(2), 0, -1);
      step(therm_t'(32'h0000_0003), 1'b0, -1, -1, -1);
      step(therm_t'(32'h0000_0003), 1'b0, -1, -1, -1);
      step(therm_t'(32'h0000_003F), 1'b1, 6, 0, -1);
      idle(5);

`ifdef THERM2BIN_HYST_EN
      // Hysteresis: held 10, single 11 holds, repeated 11 moves, 13 jumps.
      step(therm_t'(32'h0000_03FF), 1'b1, 10, 0, -1);
      step(therm_t'(32'h0000_03FF), 1'b1, 10, 0, -1);
      step(therm_t'(32'h0000_07FF), 1'b1, 10, 0, -1);
      step(therm_t'(32'h0000_07FF), 1'b1, 11, 0, -1);
      step(therm_t'(32'h0000_1FFF), 1'b1, 13, 0, -1);
      idle(5);
`endif

      // Reset mid-stream: out_valid must drop immediately.
      step(therm_t'(32'h0000_000F), 1'b1, -1, -1, -1);
      step(therm_t'(32'h0000_00FF), 1'b1, -1, -1, -1);
      step(therm_t'(32'h0000_0FFF), 1'b1, -1, -1, -1);
      step(therm_t'(32'h0000_FFFF), 1'b1, -1, -1, -1);
      chk("pre_reset_out_valid", int'(out_valid), 1);
      rstn = 1'b0;
      model_reset();
      #1;
      chk("async_reset_out_valid", int'(out_valid), 0);
      chk("async_reset_out", int'(out), 0);
      chk("async_reset_stable", int'(stable), 0);
      in_valid = 1'b0;
      idle(3);
      rstn = 1'b1;
      idle(3);

      // First valid after reset loads the counter afresh.
      step(therm_t'(32'h0000_0007), 1'b1, nh(3), 0, nh(0));
      idle(2);

      // Drain with a bound.
      for (int i = 0; i < 10 && eq.size() > 0; i++) idle(1);
      if (eq.size() > 0) chk("drain_timeout", eq.size(), 0);
      idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
